// File: rtl/mem_access_seq.sv
// Memory-access sequencer: turns SLC-3 control-unit requests into timed async-SRAM
// cycles with programmable wait states, plus one memory-mapped I/O address.
module mem_access_seq #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_rdy,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_out,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD, IO_ACK, DONE
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  cnt_reg;
  logic [15:0] wdata_reg;
  logic        dq_en_reg;

  logic req_wr;
  logic req_rd;
  logic is_io;
  logic mem_cycle_next;

  // Write has priority when both requests are low together.
  assign req_wr = !Mem_WE;
  assign req_rd = !Mem_OE && Mem_WE;
  assign is_io  = (ADDR == IO_ADDR);

  assign SRAM_DQ = dq_en_reg ? wdata_reg : 16'bz;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_wr || req_rd) begin
          if (is_io)       state_next = IO_ACK;
          else if (req_wr) state_next = WR_SETUP;
          else             state_next = RD;
        end
      end
      RD:       if (cnt_reg == 3'd0) state_next = RD_ACK;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (cnt_reg == 3'd0) state_next = WR_HOLD;
      RD_ACK,
      IO_ACK,
      WR_HOLD:  state_next = DONE;
      DONE:     if (Mem_OE && Mem_WE) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign mem_cycle_next = (state_next inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});

  // Strobes are registered from the next state so they change cleanly on the edge,
  // while the asynchronous reset still releases them without waiting for a clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      wdata_reg   <= 16'h0000;
      dq_en_reg   <= 1'b0;
      SRAM_ADDR   <= 20'h00000;
      Data_to_CPU <= 16'h0000;
      HEX_out     <= 16'h0000;
      Mem_rdy     <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      state_reg <= state_next;
      SRAM_CE_N <= !mem_cycle_next;
      SRAM_UB_N <= !mem_cycle_next;
      SRAM_LB_N <= !mem_cycle_next;
      SRAM_OE_N <= !(state_next == RD);
      SRAM_WE_N <= !(state_next == WR_PULSE);
      dq_en_reg <= (state_next inside {WR_SETUP, WR_PULSE, WR_HOLD});
      Mem_rdy   <= (state_next inside {RD_ACK, IO_ACK, WR_HOLD});

      case (state_reg)
        IDLE: begin
          if (req_wr || req_rd) begin
            SRAM_ADDR <= ADDR;
            wdata_reg <= Data_from_CPU;
            cnt_reg   <= WAIT_INIT;
            if (is_io) begin
              if (req_wr) HEX_out     <= Data_from_CPU;
              else        Data_to_CPU <= Switches;
            end
          end
        end
        RD: begin
          if (cnt_reg == 3'd0) Data_to_CPU <= SRAM_DQ;
          else                 cnt_reg     <= cnt_reg - 3'd1;
        end
        WR_SETUP: cnt_reg <= WAIT_INIT;
        WR_PULSE: if (cnt_reg != 3'd0) cnt_reg <= cnt_reg - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: table of accesses against a small SRAM model,
// plus hand sequences for reset idle state and reset during a write pulse.
module tb_mem_access_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b1;
  logic        Mem_WE = 1'b1;
  logic [19:0] ADDR = 20'h0;
  logic [15:0] Data_from_CPU = 16'h0;
  logic [15:0] Switches = 16'hBEEF;
  logic [15:0] Data_to_CPU;
  logic        Mem_rdy;
  logic [15:0] HEX_out;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int tests = 0;
  int fails = 0;

  mem_access_seq #(.WAIT_CYCLES(1), .IO_ADDR(20'h0FFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_rdy(Mem_rdy),
    .Switches(Switches), .HEX_out(HEX_out), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 Clk = ~Clk;

  // Async SRAM model: drives the bus while selected and output-enabled, captures on WE low.
  logic [15:0] sram [0:255];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR[7:0]] : 16'bz;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
      sram[16] <= 16'h1234;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      sram[SRAM_ADDR[7:0]] <= SRAM_DQ;
    end
  end

  function automatic logic dq_idle();
    return $isunknown(SRAM_DQ) || (SRAM_DQ == 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        oe;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] exp_data;
    logic [15:0] exp_hex;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
    int          exp_ce;
  } vec_t;

  vec_t vecs [7];

  // Request is held low well past completion to prove it is serviced only once.
  task automatic run_access(input vec_t v, output int lat, output int oe_c, output int we_c,
                            output int ce_c, output int rdy_c, output int dq_bad,
                            output int overlap);
    lat = -1; oe_c = 0; we_c = 0; ce_c = 0; rdy_c = 0; dq_bad = 0; overlap = 0;
    @(negedge Clk);
    Mem_OE = v.oe; Mem_WE = v.we; ADDR = v.addr; Data_from_CPU = v.wdata; Switches = v.sw;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (Mem_rdy) begin
        rdy_c++;
        if (lat < 0) lat = k;
      end
      if (!SRAM_OE_N) oe_c++;
      if (!SRAM_WE_N) we_c++;
      if (!SRAM_CE_N) ce_c++;
      if (!SRAM_OE_N && !SRAM_WE_N) overlap++;
      if (!SRAM_CE_N && SRAM_OE_N) begin
        if (SRAM_DQ !== v.wdata) dq_bad++;
      end else if (SRAM_CE_N && !dq_idle()) begin
        dq_bad++;
      end
      if (k == 1) begin
        ADDR = v.addr ^ 20'h00F0F; Data_from_CPU = ~v.wdata; Switches = ~v.sw;
      end
    end
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (Mem_rdy) rdy_c++;
    end
  endtask

  initial begin
    int lat, oe_c, we_c, ce_c, rdy_c, dq_bad, overlap, strobe_low, found;

    vecs[0] = '{"rd_10",   1'b0, 1'b1, 20'h00010, 16'h0000, 16'hBEEF, 16'h1234, 16'h0000, 3, 2, 0, 2};
    vecs[1] = '{"wr_20",   1'b1, 1'b0, 20'h00020, 16'hA5A5, 16'hBEEF, 16'h1234, 16'h0000, 4, 0, 2, 4};
    vecs[2] = '{"rd_20",   1'b0, 1'b1, 20'h00020, 16'h0000, 16'hBEEF, 16'hA5A5, 16'h0000, 3, 2, 0, 2};
    vecs[3] = '{"io_wr",   1'b1, 1'b0, 20'h0FFFF, 16'h00C3, 16'hBEEF, 16'hA5A5, 16'h00C3, 1, 0, 0, 0};
    vecs[4] = '{"io_rd",   1'b0, 1'b1, 20'h0FFFF, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h00C3, 1, 0, 0, 0};
    vecs[5] = '{"both_30", 1'b0, 1'b0, 20'h00030, 16'h0F0F, 16'hBEEF, 16'h5A5A, 16'h00C3, 4, 0, 2, 4};
    vecs[6] = '{"rd_30",   1'b0, 1'b1, 20'h00030, 16'h0000, 16'hBEEF, 16'h0F0F, 16'h00C3, 3, 2, 0, 2};

    // Reset, then idle with no requests.
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    strobe_low = 0; rdy_c = 0; dq_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || !SRAM_UB_N || !SRAM_LB_N) strobe_low++;
      if (Mem_rdy) rdy_c++;
      if (!dq_idle()) dq_bad++;
    end
    check("idle_strobes_low", strobe_low, 0);
    check("idle_rdy", rdy_c, 0);
    check("idle_dq", dq_bad, 0);
    check("idle_hex", HEX_out, 16'h0000);
    check("idle_data", Data_to_CPU, 16'h0000);
    check("idle_addr", SRAM_ADDR, 20'h00000);
    $display("[TB] reset/idle: strobes_low=%0d rdy=%0d hex=%h", strobe_low, rdy_c, HEX_out);

    for (int i = 0; i < 7; i++) begin
      run_access(vecs[i], lat, oe_c, we_c, ce_c, rdy_c, dq_bad, overlap);
      $display("[TB] %s lat=%0d oe=%0d we=%0d ce=%0d rdy=%0d data=%h hex=%h",
               vecs[i].name, lat, oe_c, we_c, ce_c, rdy_c, Data_to_CPU, HEX_out);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_rdy_pulses"}, rdy_c, 1);
      check({vecs[i].name, "_oe_cycles"}, oe_c, vecs[i].exp_oe);
      check({vecs[i].name, "_we_cycles"}, we_c, vecs[i].exp_we);
      check({vecs[i].name, "_ce_cycles"}, ce_c, vecs[i].exp_ce);
      check({vecs[i].name, "_dq"}, dq_bad, 0);
      check({vecs[i].name, "_oe_we_overlap"}, overlap, 0);
      check({vecs[i].name, "_data"}, Data_to_CPU, vecs[i].exp_data);
      check({vecs[i].name, "_hex"}, HEX_out, vecs[i].exp_hex);
    end
    check("sram_20", sram[8'h20], 16'hA5A5);
    check("sram_30", sram[8'h30], 16'h0F0F);

    // Reset during the write pulse must drop strobes without a clock edge.
    @(negedge Clk);
    Mem_WE = 1'b0; ADDR = 20'h00040; Data_from_CPU = 16'h1111;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) found = 1;
    end
    check("rst_wr_pulse_reached", found, 1);
    Reset = 1'b1;
    #1;
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_ce_n", SRAM_CE_N, 1'b1);
    check("rst_oe_n", SRAM_OE_N, 1'b1);
    check("rst_dq", dq_idle(), 1'b1);
    check("rst_rdy", Mem_rdy, 1'b0);
    Mem_WE = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    rdy_c = 0; strobe_low = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Mem_rdy) rdy_c++;
      if (!SRAM_CE_N || !SRAM_WE_N || !SRAM_OE_N) strobe_low++;
    end
    $display("[TB] reset_mid_write: rdy=%0d strobes_low=%0d", rdy_c, strobe_low);
    check("rst_after_rdy", rdy_c, 0);
    check("rst_after_strobes", strobe_low, 0);
    check("rst_after_data", Data_to_CPU, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
